a2d_spi_responder: RTL and testbench



---
 rtl/a2d_pkg.sv | 16 +
 rtl/a2d_spi_responder_sync_edge.sv | 34 +++
 rtl/a2d_spi_responder.sv | 147 ++++++++++++++
 tb/tb_a2d_spi_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared A2D SPI constants and state encoding, common to the master-side
// A2D interface and the responder.
package a2d_pkg;

    localparam int CMD_W    = 16;
    localparam int CHNL_MSB = 13;
    localparam int CHNL_LSB = 11;
    localparam int RESP_PAD = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CONV
    } a2d_rsp_state_t;

endpackage

// File: rtl/a2d_spi_responder_sync_edge.sv
// Multi-flop synchronizer with one extra flop for rise/fall detection.
// RST_VAL sets the level assumed for the pin while in reset, so that an
// idle-high input does not produce a spurious edge when reset releases.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/a2d_spi_responder.sv
// SPI slave model of the 8-channel 12-bit A2D converter. Commands arrive on
// MOSI; the selected channel is captured when the frame ends and returned
// MSB first on MISO during the next frame.
// Optional build macro: A2D_CMD_CHECK_EN adds cmd_err and rejects commands
// with non-zero header or trailing bits.
//
//   state | meaning
//   IDLE  | SS_n high, waiting for SS_n fall
//   SHIFT | frame active: sample MOSI on SCLK rise, shift MISO on SCLK fall
//   CONV  | one clk: latch command, capture channel sample, pulse cnv_done
module a2d_spi_responder
    import a2d_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     cnv_done,
    output logic [2:0]               last_chnnl,
    output logic [CMD_W-1:0]         cmd_rx
`ifdef A2D_CMD_CHECK_EN
    ,
    output logic                     cmd_err
`endif
);

    logic ss_sync_unused, ss_rise, ss_fall;
    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(SS_n),
        .sync(ss_sync_unused), .rise(ss_rise), .fall(ss_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(MOSI),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    a2d_rsp_state_t    state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0]  rx_q, rx_d;
    logic [CMD_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0] conv_q, conv_d;
    logic [CMD_W-1:0]  cmd_rx_q, cmd_rx_d;
    logic [2:0]        chnl_q, chnl_d;
    logic              cmd_bad;

    // Malformed-command detect; constant 0 when checking is not built in.
    always_comb begin
        cmd_bad = 1'b0;
`ifdef A2D_CMD_CHECK_EN
        cmd_bad = (rx_q[CMD_W-1:CHNL_MSB+1] != '0) || (rx_q[CHNL_LSB-1:0] != '0);
`endif
    end

    // Next-state logic; within SHIFT the SCLK edge is applied before the
    // SS_n rise decision so a coincident last rise still completes the frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        conv_d    = conv_q;
        cmd_rx_d  = cmd_rx_q;
        chnl_d    = chnl_q;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d               = '0;
                    tx_d[DATA_W-1:0]   = conv_q;
                    bit_cnt_d          = '0;
                    state_d            = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise && bit_cnt_q < 5'd16) begin
                    rx_d      = {rx_q[CMD_W-2:0], mosi_sync};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall && bit_cnt_q != 5'd0) begin
                    tx_d = {tx_q[CMD_W-2:0], 1'b0};
                end
                if (ss_rise) begin
                    state_d = (bit_cnt_d == 5'd16) ? CONV : IDLE;
                end
            end
            CONV: begin
                cmd_rx_d = rx_q;
                chnl_d   = rx_q[CHNL_MSB:CHNL_LSB];
                if (!cmd_bad) begin
                    conv_d = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (rx_q[CHNL_MSB:CHNL_LSB] == 3'(k)) begin
                            conv_d = ch_data[k*DATA_W +: DATA_W];
                        end
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            conv_q    <= '0;
            cmd_rx_q  <= '0;
            chnl_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            conv_q    <= conv_d;
            cmd_rx_q  <= cmd_rx_d;
            chnl_q    <= chnl_d;
        end
    end

    assign MISO       = (state_q == SHIFT) & tx_q[CMD_W-1];
    assign cnv_done   = (state_q == CONV) & ~cmd_bad;
    assign last_chnnl = chnl_q;
    assign cmd_rx     = cmd_rx_q;
`ifdef A2D_CMD_CHECK_EN
    assign cmd_err    = (state_q == CONV) & cmd_bad;
`endif

endmodule

// File: tb/tb_a2d_spi_responder.sv
// Scoreboard bench for a2d_spi_responder: the stimulus thread pushes the
// expected MISO word and expected conversion results; monitors pop and
// compare when the DUT completes a frame or pulses cnv_done.
module tb_a2d_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] ch_data;
    logic        cnv_done;
    logic [2:0]  last_chnnl;
    logic [15:0] cmd_rx;
`ifdef A2D_CMD_CHECK_EN
    logic        cmd_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_resp_q[$];
    logic [18:0] exp_conv_q[$];   // {chnl, cmd}
`ifdef A2D_CMD_CHECK_EN
    logic [15:0] exp_err_q[$];
`endif

    a2d_spi_responder dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .ch_data(ch_data), .cnv_done(cnv_done),
        .last_chnnl(last_chnnl), .cmd_rx(cmd_rx)
`ifdef A2D_CMD_CHECK_EN
        , .cmd_err(cmd_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one frame; nbits SCLK pulses, bits past 16 are driven as 1.
    task automatic frame(input logic [15:0] cmd, input int nbits, input bit close);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'b1;
            repeat (3) @(negedge clk);
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
            repeat (2) @(negedge clk);
        end
        if (close) begin
            repeat (4) @(negedge clk);
            SS_n = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    // MISO monitor: master samples on SCLK rise; compare the first 16 bits
    // of every frame that reached 16 rises.
    logic [15:0] miso_word = '0;
    int          miso_n    = 0;
    always @(posedge SCLK) begin
        if (miso_n < 16) miso_word = {miso_word[14:0], MISO};
        miso_n++;
    end
    always @(posedge SS_n) begin
        if (miso_n >= 16) begin
            if (exp_resp_q.size() == 0) begin
                chk("resp_unexpected", 32'(miso_word), 32'hFFFF_FFFF);
            end else begin
                chk("miso_resp", 32'(miso_word), 32'(exp_resp_q.pop_front()));
            end
        end
        miso_n    = 0;
        miso_word = '0;
    end

    // Conversion monitor.
    always @(negedge clk) begin
        if (cnv_done === 1'b1) begin
            if (exp_conv_q.size() == 0) begin
                chk("cnv_done_unexpected", 32'(cnv_done), 32'h0);
            end else begin
                logic [18:0] e;
                e = exp_conv_q.pop_front();
                @(posedge clk);
                #1;
                chk("last_chnnl", 32'(last_chnnl), 32'(e[18:16]));
                chk("cmd_rx", 32'(cmd_rx), 32'(e[15:0]));
            end
        end
    end

`ifdef A2D_CMD_CHECK_EN
    always @(negedge clk) begin
        if (cmd_err === 1'b1) begin
            if (exp_err_q.size() == 0) begin
                chk("cmd_err_unexpected", 32'(cmd_err), 32'h0);
            end else begin
                logic [15:0] e;
                e = exp_err_q.pop_front();
                @(posedge clk);
                #1;
                chk("cmd_rx_on_err", 32'(cmd_rx), 32'(e));
            end
        end
    end
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        ch_data = '0;
        ch_data[0*12 +: 12] = 12'h123;
        ch_data[1*12 +: 12] = 12'h111;
        ch_data[3*12 +: 12] = 12'hABC;
        ch_data[5*12 +: 12] = 12'h555;
        ch_data[7*12 +: 12] = 12'hFFF;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(MISO), 32'h0);
        chk("rst_cnv_done", 32'(cnv_done), 32'h0);
        chk("rst_cmd_rx", 32'(cmd_rx), 32'h0);
        chk("rst_last_chnnl", 32'(last_chnnl), 32'h0);

        exp_resp_q.push_back(16'h0000); exp_conv_q.push_back({3'd3, 16'h1800});
        frame(16'h1800, 16, 1'b1);
        exp_resp_q.push_back(16'h0ABC); exp_conv_q.push_back({3'd0, 16'h0000});
        frame(16'h0000, 16, 1'b1);
        exp_resp_q.push_back(16'h0123); exp_conv_q.push_back({3'd7, 16'h3800});
        frame(16'h3800, 16, 1'b1);
        exp_resp_q.push_back(16'h0FFF); exp_conv_q.push_back({3'd0, 16'h0000});
        frame(16'h0000, 16, 1'b1);

        // Abort after 7 rises: no conversion, sample register kept.
        frame(16'h1800, 7, 1'b1);
        chk("abort_cmd_rx", 32'(cmd_rx), 32'h0000);
        chk("abort_last_chnnl", 32'(last_chnnl), 32'h0);
        exp_resp_q.push_back(16'h0123); exp_conv_q.push_back({3'd5, 16'h2800});
        frame(16'h2800, 16, 1'b1);

        // Reset after 9 bits of a frame.
        frame(16'h2800, 9, 1'b0);
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_miso", 32'(MISO), 32'h0);
        chk("midrst_cmd_rx", 32'(cmd_rx), 32'h0);
        chk("midrst_last_chnnl", 32'(last_chnnl), 32'h0);
        chk("midrst_cnv_done", 32'(cnv_done), 32'h0);
        exp_resp_q.push_back(16'h0000); exp_conv_q.push_back({3'd5, 16'h2800});
        frame(16'h2800, 16, 1'b1);

        // Malformed header command.
        exp_resp_q.push_back(16'h0555);
`ifdef A2D_CMD_CHECK_EN
        exp_err_q.push_back(16'hC800);
        frame(16'hC800, 16, 1'b1);
        exp_resp_q.push_back(16'h0555);
`else
        exp_conv_q.push_back({3'd1, 16'hC800});
        frame(16'hC800, 16, 1'b1);
        exp_resp_q.push_back(16'h0111);
`endif
        exp_conv_q.push_back({3'd0, 16'h0000});
        frame(16'h0000, 16, 1'b1);

        // 18 rises: extra rises ignored, frame still completes.
        exp_resp_q.push_back(16'h0123); exp_conv_q.push_back({3'd1, 16'h0800});
        frame(16'h0800, 18, 1'b1);
        exp_resp_q.push_back(16'h0111); exp_conv_q.push_back({3'd0, 16'h0000});
        frame(16'h0000, 16, 1'b1);

        repeat (10) @(negedge clk);
        chk("resp_queue_drained", 32'(exp_resp_q.size()), 32'h0);
        chk("conv_queue_drained", 32'(exp_conv_q.size()), 32'h0);
`ifdef A2D_CMD_CHECK_EN
        chk("err_queue_drained", 32'(exp_err_q.size()), 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
